// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one single-port BRAM between a write requester
// and a read requester, tracks the one-cycle read latency and buffers read
// data in a 2-entry response FIFO. Out-of-range requests are accepted but
// not issued, and they raise a sticky addr_err.
// Build option: define BRAM_ARB_FIXED_PRIO_EN to make writes always win on
// conflict. When it is undefined (the default), arbitration is round-robin.
module bram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 48
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  bram_ce,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_wdata,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic                  addr_err
);

   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   logic [1:0]            count_q, count_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic                  inflight_q, inflight_d;
   logic                  inflight_oor_q, inflight_oor_d;
   logic                  addr_err_q, addr_err_d;

   logic wr_oor, rd_oor, credit_ok, wr_elig, rd_elig;
   logic grant_wr, grant_rd, push, pop;
   logic [DATA_WIDTH-1:0] push_data;

   assign wr_oor = ({1'b0, wr_addr} >= DEPTH_LIM);
   assign rd_oor = ({1'b0, rd_addr} >= DEPTH_LIM);

   assign rsp_valid = (count_q != 2'd0);
   assign rsp_data  = mem_q[rd_ptr_q];
   assign addr_err  = addr_err_q;
   assign pop       = rsp_valid && rsp_ready;
   assign push      = inflight_q;
   assign push_data = inflight_oor_q ? DATA_WIDTH'(0) : bram_rdata;

   // Read credit: buffered + in flight - leaving this cycle must stay below 2.
   assign credit_ok = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
   assign wr_elig   = rst_n && wr_valid;
   assign rd_elig   = rst_n && rd_valid && credit_ok;

`ifdef BRAM_ARB_FIXED_PRIO_EN
   // Fixed priority: write always wins a conflict.
   always_comb begin
      grant_wr = wr_elig;
      grant_rd = rd_elig && !wr_elig;
   end
`else
   logic last_rd_q, last_rd_d;

   // Round-robin: on conflict the requester not granted most recently wins.
   always_comb begin
      grant_wr  = wr_elig && (!rd_elig || last_rd_q);
      grant_rd  = rd_elig && (!wr_elig || !last_rd_q);
      last_rd_d = last_rd_q;
      if (grant_wr || grant_rd) begin
         last_rd_d = grant_rd;
      end
   end

   // Last-grant register; reset to read so the first tie goes to the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_rd_q <= 1'b1;
      end else begin
         last_rd_q <= last_rd_d;
      end
   end
`endif

   assign wr_ready = grant_wr;
   assign rd_ready = grant_rd;

   // BRAM port drive; out-of-range grants are accepted but not issued.
   always_comb begin
      bram_ce    = 1'b0;
      bram_we    = 1'b0;
      bram_addr  = '0;
      bram_wdata = '0;
      if (grant_wr && !wr_oor) begin
         bram_ce    = 1'b1;
         bram_we    = 1'b1;
         bram_addr  = wr_addr;
         bram_wdata = wr_data;
      end else if (grant_rd && !rd_oor) begin
         bram_ce    = 1'b1;
         bram_addr  = rd_addr;
      end
   end

   // Next state for the in-flight tracker, response FIFO and error flag.
   always_comb begin
      inflight_d     = grant_rd;
      inflight_oor_d = grant_rd && rd_oor;
      addr_err_d     = addr_err_q || (grant_wr && wr_oor) || (grant_rd && rd_oor);
      mem_d          = mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q + 2'(push) - 2'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = !wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = !rd_ptr_q;
      end
   end

   // State registers; reset discards buffered and in-flight reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q        <= 2'd0;
         rd_ptr_q       <= 1'b0;
         wr_ptr_q       <= 1'b0;
         mem_q[0]       <= '0;
         mem_q[1]       <= '0;
         inflight_q     <= 1'b0;
         inflight_oor_q <= 1'b0;
         addr_err_q     <= 1'b0;
      end else begin
         count_q        <= count_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         mem_q[0]       <= mem_d[0];
         mem_q[1]       <= mem_d[1];
         inflight_q     <= inflight_d;
         inflight_oor_q <= inflight_oor_d;
         addr_err_q     <= addr_err_d;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural BRAM, a shadow
// memory and a response scoreboard.
module tb_bram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid, wr_ready, rd_valid, rd_ready;
   logic [5:0] wr_addr, rd_addr, bram_addr;
   logic [7:0] wr_data, rsp_data, bram_wdata, bram_rdata;
   logic       rsp_valid, rsp_ready, bram_ce, bram_we, addr_err;

   int total = 0;
   int bad   = 0;
   logic [7:0] bmem   [64];
   logic [7:0] shadow [64];
   logic [7:0] sbq [$];

   always #5 clk = ~clk;

   bram_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .bram_ce(bram_ce), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .addr_err(addr_err)
   );

   // Single-port BRAM with registered read data.
   always @(posedge clk) begin
      if (bram_ce) begin
         if (bram_we) bmem[bram_addr] <= bram_wdata;
         else         bram_rdata      <= bmem[bram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: push expected read data on accept, compare on response pop.
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) check("sb_unexpected_rsp", 32'(rsp_data), 32'hDEAD);
            else                 check("sb_rsp_data", 32'(rsp_data), 32'(sbq.pop_front()));
         end
         if (wr_valid && wr_ready && wr_addr < 6'd48) shadow[wr_addr] = wr_data;
         if (rd_valid && rd_ready) sbq.push_back(rd_addr < 6'd48 ? shadow[rd_addr] : 8'h00);
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sbq.size() != 0 || rsp_valid) && n < 20) begin
         next_cyc();
         n++;
      end
      check(tag, 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      int wi, ri, acc;
      logic exp_w;
      for (int i = 0; i < 64; i++) begin
         bmem[i]   = 8'h00;
         shadow[i] = 8'h00;
      end
      bram_rdata = 8'h00;
      rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;

      // Reset state, with requests present.
      repeat (2) @(posedge clk);
      #1 wr_valid = 1'b1; rd_valid = 1'b1;
      @(negedge clk);
      check("rst_wr_ready", 32'(wr_ready), 32'd0);
      check("rst_rd_ready", 32'(rd_ready), 32'd0);
      check("rst_bram_ce", 32'(bram_ce), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      wr_valid = 1'b0; rd_valid = 1'b0;
      next_cyc();
      rst_n = 1'b1;
      next_cyc();

      // Write 5 <- A5, then read it back with 2-cycle latency.
      rsp_ready = 1'b1;
      wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 8'hA5;
      @(negedge clk);
      check("w1_wr_ready", 32'(wr_ready), 32'd1);
      check("w1_bram_we", 32'(bram_we), 32'd1);
      check("w1_bram_addr", 32'(bram_addr), 32'd5);
      next_cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd5;
      @(negedge clk);
      check("r1_rd_ready", 32'(rd_ready), 32'd1);
      check("r1_bram_we", 32'(bram_we), 32'd0);
      check("r1_bram_ce", 32'(bram_ce), 32'd1);
      next_cyc();
      rd_valid = 1'b0;
      @(negedge clk);
      check("r1_lat_n1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("r1_lat_n2", 32'(rsp_valid), 32'd1);
      check("r1_data", 32'(rsp_data), 32'hA5);
      next_cyc();
      wait_drain("r1_drain");

      // Full contention for 8 cycles.
      wi = 0; ri = 0;
      wr_valid = 1'b1; rd_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         wr_addr = 6'(10 + wi); wr_data = 8'(8'h80 + wi); rd_addr = 6'(20 + ri);
         @(negedge clk);
`ifdef BRAM_ARB_FIXED_PRIO_EN
         exp_w = 1'b1;
`else
         exp_w = (c % 2 == 0);
`endif
         check("cont_wr_ready", 32'(wr_ready), 32'(exp_w));
         check("cont_rd_ready", 32'(rd_ready), 32'(!exp_w));
         if (wr_ready) wi++;
         if (rd_ready) ri++;
         next_cyc();
      end
      wr_valid = 1'b0;
      for (int c = 0; c < 12 && ri < 4; c++) begin
         rd_addr = 6'(20 + ri);
         @(negedge clk);
         if (rd_ready) ri++;
         next_cyc();
      end
      rd_valid = 1'b0;
      check("cont_reads", 32'(ri), 32'd4);
      wait_drain("cont_drain");

      // Response stall: only two reads may be outstanding.
      rsp_ready = 1'b0; rd_valid = 1'b1; acc = 0;
      for (int c = 0; c < 6; c++) begin
         rd_addr = 6'(10 + acc);
         @(negedge clk);
         if (rd_ready) acc++;
         next_cyc();
      end
      check("stall_accepts", 32'(acc), 32'd2);
      @(negedge clk);
      check("stall_rd_ready", 32'(rd_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      next_cyc();
      rsp_ready = 1'b1;
      for (int c = 0; c < 20 && acc < 4; c++) begin
         rd_addr = 6'(10 + acc);
         @(negedge clk);
         if (rd_ready) acc++;
         next_cyc();
      end
      rd_valid = 1'b0;
      check("stall_resume", 32'(acc), 32'd4);
      wait_drain("stall_drain");

      // Preload 0..7 with 10..17, then back-to-back reads.
      wr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_addr = 6'(i); wr_data = 8'(8'h10 + i);
         @(negedge clk);
         check("pre_wr_ready", 32'(wr_ready), 32'd1);
         next_cyc();
      end
      wr_valid = 1'b0; rd_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_addr = 6'(i);
         @(negedge clk);
         check("b2b_rd_ready", 32'(rd_ready), 32'd1);
         next_cyc();
      end
      rd_valid = 1'b0;
      wait_drain("b2b_drain");

      // Out-of-range write and read.
      wr_valid = 1'b1; wr_addr = 6'd50; wr_data = 8'hFF;
      @(negedge clk);
      check("oor_wr_ready", 32'(wr_ready), 32'd1);
      check("oor_wr_ce", 32'(bram_ce), 32'd0);
      next_cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd50;
      @(negedge clk);
      check("oor_addr_err", 32'(addr_err), 32'd1);
      check("oor_rd_ready", 32'(rd_ready), 32'd1);
      check("oor_rd_ce", 32'(bram_ce), 32'd0);
      next_cyc();
      rd_valid = 1'b0;
      wait_drain("oor_drain");
      check("oor_addr_err_sticky", 32'(addr_err), 32'd1);

      // Reset with one read in flight and one FIFO entry.
      rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 6'd0;
      @(negedge clk);
      check("mr_rd0", 32'(rd_ready), 32'd1);
      next_cyc();
      rd_addr = 6'd1;
      @(negedge clk);
      check("mr_rd1", 32'(rd_ready), 32'd1);
      next_cyc();
      rd_valid = 1'b0;
      @(negedge clk);
      check("mr_pre_rsp_valid", 32'(rsp_valid), 32'd1);
      #1 rst_n = 1'b0; wr_valid = 1'b1;
      #1;
      check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mr_rsp_data", 32'(rsp_data), 32'd0);
      check("mr_addr_err", 32'(addr_err), 32'd0);
      check("mr_wr_ready", 32'(wr_ready), 32'd0);
      check("mr_bram_ce", 32'(bram_ce), 32'd0);
      wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("mr_no_rsp", 32'(rsp_valid), 32'd0);
         next_cyc();
      end
      rd_valid = 1'b1; rd_addr = 6'd3;
      @(negedge clk);
      check("mr_new_rd", 32'(rd_ready), 32'd1);
      next_cyc();
      rd_valid = 1'b0;
      wait_drain("mr_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
